// File: rtl/serpent_enc_core_if.sv
// Request/response bundle for serpent_enc_core.
// Master drives start and subkey data; slave returns results.
`timescale 1ns/1ps
interface serpent_enc_core_if;
  logic         i_en;
  logic         i_subkey_valid;
  logic [127:0] i_data;
  logic [127:0] i_key;
  logic [5:0]   o_address;
  logic [127:0] o_data;
  logic         o_data_valid;
  logic         o_busy;

  modport master (
    output i_en,
    output i_subkey_valid,
    output i_data,
    output i_key,
    input  o_address,
    input  o_data,
    input  o_data_valid,
    input  o_busy
  );

  modport slave (
    input  i_en,
    input  i_subkey_valid,
    input  i_data,
    input  i_key,
    output o_address,
    output o_data,
    output o_data_valid,
    output o_busy
  );
endinterface

// File: rtl/serpent_enc_core.sv
// Iterative Serpent encryptor, one round per clock.
// Option SERPENT_ENC_ABORT_EN: abort when subkeys go invalid.
`timescale 1ns/1ps

module initial_permutation (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar i = 0; i < 128; i++) begin : g_bit
    assign data_o[i] = data_i[(i % 4) * 32 + i / 4];
  end
endmodule

module final_permutation (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar i = 0; i < 128; i++) begin : g_bit
    assign data_o[i] = data_i[(i % 32) * 4 + i / 32];
  end
endmodule

module serpent_enc_core (
  input  logic              i_clk,
  input  logic              i_rstn,
  serpent_enc_core_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_t;

  // Nibble n of entry b holds S_b(n).
  localparam logic [63:0] SBOX [8] = '{
    64'hC90724DEB56A1F83,
    64'h43D68EB1A50972CF,
    64'h25B04E1DFAC39768,
    64'hE57A421D369C8BF0,
    64'hD7E9A4526B0C38F1,
    64'h176D8E30C9A4B25F,
    64'h0A3DF19EB6485C27,
    64'h5639AC47B28E0FD1
  };

  state_t       state_q;
  logic [5:0]   rnd_q;
  logic [5:0]   addr_q;
  logic [127:0] x_q;
  logic [127:0] data_q;
  logic         valid_q;
  logic         busy_q;

  logic [127:0] t;
  logic [127:0] s_out;
  logic [127:0] ip_in;
  logic [127:0] fp_lt;
  logic [127:0] lt_w;
  logic [127:0] lt_out;
  logic [127:0] fp_out;
  logic         abort;
  logic         last;

  function automatic logic [31:0] rol(
    input logic [31:0] v,
    input int          n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] v);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = v;
    w0 = rol(w0, 13);
    w2 = rol(w2, 3);
    w1 = w1 ^ w0 ^ w2;
    w3 = w3 ^ w2 ^ (w0 << 3);
    w1 = rol(w1, 1);
    w3 = rol(w3, 7);
    w0 = w0 ^ w1 ^ w3;
    w2 = w2 ^ w3 ^ (w1 << 7);
    w0 = rol(w0, 5);
    w2 = rol(w2, 22);
    return {w3, w2, w1, w0};
  endfunction

`ifdef SERPENT_ENC_ABORT_EN
  assign abort = ~bus.i_subkey_valid;
`else
  assign abort = 1'b0;
`endif

  assign last = (rnd_q == 6'd31);
  assign t    = x_q ^ bus.i_key;

  // Key mix already in t; substitute every nibble.
  always_comb begin
    s_out = '0;
    for (int n = 0; n < 32; n++) begin
      s_out[4*n +: 4] =
        SBOX[rnd_q[2:0]][{t[4*n +: 4], 2'b00} +: 4];
    end
  end

  initial_permutation u_ip_in (
    .data_i (bus.i_data),
    .data_o (ip_in)
  );

  final_permutation u_fp_lt (
    .data_i (s_out),
    .data_o (fp_lt)
  );

  assign lt_w = lt(fp_lt);

  initial_permutation u_ip_lt (
    .data_i (lt_w),
    .data_o (lt_out)
  );

  final_permutation u_fp_out (
    .data_i (t),
    .data_o (fp_out)
  );

  // Round sequencer; all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_en && bus.i_subkey_valid) begin
            x_q     <= ip_in;
            rnd_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            rnd_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            x_q    <= last ? s_out : lt_out;
            rnd_q  <= rnd_q + 6'd1;
            addr_q <= rnd_q + 6'd1;
            if (last) state_q <= FINAL;
          end
        end
        FINAL: begin
          if (!abort) begin
            data_q  <= fp_out;
            valid_q <= 1'b1;
          end
          rnd_q   <= '0;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_address    = addr_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_serpent_enc_core.sv
// Scoreboard bench for serpent_enc_core.
// Reference model works in the bitslice word domain.
`timescale 1ns/1ps
module tb_serpent_enc_core;
  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;

  serpent_enc_core_if bus ();

  serpent_enc_core dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] data;
    int unsigned  cyc;
  } exp_t;

  exp_t         exp_q [$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  logic [127:0] last_exp = '0;
  logic [127:0] store [64];
  logic [127:0] ks [33];

  int SB [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 6, 5}
  };

  always @(posedge i_clk) cyc <= cyc + 1;

  // Combinational subkey store read.
  always_comb bus.i_key = store[bus.o_address];

  function automatic logic [31:0] rotl(
    input logic [31:0] v,
    input int          n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  // Word k bit j sits at standard-domain bit 4j+k.
  function automatic logic [127:0] to_ip(input logic [127:0] w);
    logic [127:0] o;
    for (int j = 0; j < 32; j++)
      for (int k = 0; k < 4; k++)
        o[4*j + k] = w[32*k + j];
    return o;
  endfunction

  function automatic logic [127:0] sbox_bs(
    input int           b,
    input logic [127:0] w
  );
    logic [127:0] o;
    int v;
    o = '0;
    for (int j = 0; j < 32; j++) begin
      v = int'({w[96+j], w[64+j], w[32+j], w[j]});
      v = SB[b][v];
      for (int k = 0; k < 4; k++) o[32*k + j] = v[k];
    end
    return o;
  endfunction

  function automatic logic [127:0] lt_bs(input logic [127:0] w);
    logic [31:0] x [4];
    for (int k = 0; k < 4; k++) x[k] = w[32*k +: 32];
    x[0] = rotl(x[0], 13);
    x[2] = rotl(x[2], 3);
    x[1] = x[1] ^ x[0] ^ x[2];
    x[3] = x[3] ^ x[2] ^ (x[0] << 3);
    x[1] = rotl(x[1], 1);
    x[3] = rotl(x[3], 7);
    x[0] = x[0] ^ x[1] ^ x[3];
    x[2] = x[2] ^ x[3] ^ (x[1] << 7);
    x[0] = rotl(x[0], 5);
    x[2] = rotl(x[2], 22);
    return {x[3], x[2], x[1], x[0]};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] p);
    logic [127:0] w;
    w = p;
    for (int r = 0; r < 32; r++) begin
      w = sbox_bs(r % 8, w ^ ks[r]);
      if (r < 31) w = lt_bs(w);
      else        w = w ^ ks[32];
    end
    return w;
  endfunction

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [140];
    for (int i = 0; i < 8; i++)
      w[i] = (i < 4) ? key[32*i +: 32] : ((i == 4) ? 32'h1 : 32'h0);
    for (int i = 8; i < 140; i++)
      w[i] = rotl(w[i-8] ^ w[i-5] ^ w[i-3] ^ w[i-1]
                  ^ 32'h9e3779b9 ^ (i - 8), 11);
    for (int n = 0; n < 33; n++) begin
      ks[n] = sbox_bs((35 - n) % 8,
        {w[4*n+11], w[4*n+10], w[4*n+9], w[4*n+8]});
      store[n] = to_ip(ks[n]);
    end
  endtask

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] want
  );
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_exp(input logic [127:0] p);
    exp_t e;
    e.data = model(p);
    e.cyc  = cyc + 34;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [127:0] p, input bit push);
    @(negedge i_clk);
    bus.i_en           = 1'b1;
    bus.i_subkey_valid = 1'b1;
    bus.i_data         = p;
    if (push) push_exp(p);
    @(posedge i_clk);
    #1;
    bus.i_en   = 1'b0;
    bus.i_data = rnd128();
  endtask

  task automatic drain();
    int i;
    #1;
    i = 0;
    while (exp_q.size() != 0 && i < 80) begin
      @(negedge i_clk);
      #1;
      i++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  // Walk one block, checking address and busy each cycle.
  task automatic run_walk(input logic [127:0] p);
    issue(p, 1'b1);
    for (int k = 0; k <= 33; k++) begin
      @(negedge i_clk);
      chk("address", 128'(bus.o_address),
          128'((k == 33) ? 0 : k));
      chk("busy", 128'(bus.o_busy), 128'(k <= 32));
      bus.i_en = (k == 5 || k == 17);
    end
    bus.i_en = 1'b0;
    drain();
  endtask

  // Pops an expected block on every valid pulse.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rstn && bus.o_data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid cyc=%0d data=%h want=none",
                 cyc, bus.o_data);
      end else begin
        e = exp_q.pop_front();
        last_exp = e.data;
        if (bus.o_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL ciphertext got=%h@%0d want=%h@%0d",
                   bus.o_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p1, p2;
    bus.i_en           = 1'b0;
    bus.i_subkey_valid = 1'b0;
    bus.i_data         = '0;
    load_keys('0);

    repeat (3) @(negedge i_clk);
    chk("rst_data", bus.o_data, '0);
    chk("rst_valid", 128'(bus.o_data_valid), '0);
    chk("rst_busy", 128'(bus.o_busy), '0);
    chk("rst_addr", 128'(bus.o_address), '0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("idle_addr", 128'(bus.o_address), '0);

    // Zero key, zero plaintext.
    run_walk('0);

    load_keys(rnd128());
    run_walk(128'h00112233445566778899AABBCCDDEEFF);

    for (int n = 0; n < 100; n++) begin
      load_keys(rnd128());
      issue(rnd128(), 1'b1);
      drain();
    end

    // Back-to-back with i_en held high.
    load_keys(rnd128());
    p1 = rnd128();
    p2 = rnd128();
    @(negedge i_clk);
    bus.i_en           = 1'b1;
    bus.i_subkey_valid = 1'b1;
    bus.i_data         = p1;
    push_exp(p1);
    @(posedge i_clk);
    #1;
    bus.i_data = p2;
    repeat (34) @(negedge i_clk);
    push_exp(p2);
    @(posedge i_clk);
    #1;
    bus.i_en = 1'b0;
    chk("b2b_busy", 128'(bus.o_busy), 128'(1));
    drain();

    // Subkey store invalidated at round 10.
    load_keys(rnd128());
    p1 = rnd128();
`ifdef SERPENT_ENC_ABORT_EN
    p2 = last_exp;
    issue(p1, 1'b0);
    repeat (11) @(negedge i_clk);
    bus.i_subkey_valid = 1'b0;
    repeat (40) @(negedge i_clk);
    chk("abort_busy", 128'(bus.o_busy), '0);
    chk("abort_addr", 128'(bus.o_address), '0);
    chk("abort_data", bus.o_data, p2);
`else
    issue(p1, 1'b1);
    repeat (11) @(negedge i_clk);
    bus.i_subkey_valid = 1'b0;
    drain();
    chk("noabort_busy", 128'(bus.o_busy), '0);
`endif
    bus.i_subkey_valid = 1'b1;

    // Reset in the middle of round 20.
    load_keys(rnd128());
    issue(rnd128(), 1'b1);
    repeat (21) @(negedge i_clk);
    chk("pre_rst_addr", 128'(bus.o_address), 128'(20));
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_data", bus.o_data, '0);
    chk("mid_rst_valid", 128'(bus.o_data_valid), '0);
    chk("mid_rst_busy", 128'(bus.o_busy), '0);
    chk("mid_rst_addr", 128'(bus.o_address), '0);
    exp_q.delete();
    last_exp = '0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    issue(rnd128(), 1'b1);
    drain();

    repeat (5) @(negedge i_clk);
    chk("queue_empty", 128'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serpent_enc_core.md
# serpent_enc_core

Iterative Serpent block-encryption core for the Serpent-XTS datapath. It computes one round per clock and fetches round subkeys from the shared key-schedule store through an address port. It is the encrypt-direction counterpart of the Serpent decryption core and accepts the same subkey store and the same permutation submodules. Plaintext enters through `initial_permutation`; ciphertext leaves through `final_permutation`.

## Interface
- No parameters.
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_en  in  1  start request, sampled in IDLE only
- i_subkey_valid  in  1  key schedule complete; subkey store readable
- i_data  in  128  plaintext, sampled on the start edge
- i_key  in  128  subkey K̂[o_address], IP domain, combinational read from the store
- o_address  out  6  subkey index 0..32
- o_data  out  128  ciphertext, held until the next completion
- o_data_valid  out  1  one-cycle completion pulse
- o_busy  out  1  high in ROUND and FINAL

## Operation
- Internal state X is 128 bits and lives in the IP (standard) domain. Nibble j = X[4j+3:4j].
- States:
  - IDLE:
    - o_address=0.
    - When i_en & i_subkey_valid: X <= IP(i_data), r <= 0, go to ROUND.
  - ROUND, for r = 0..31, with o_address=r:
    - T = X ^ i_key.
    - Apply S-box S[r mod 8] to every nibble of T.
    - For r<31: X <= IP(LT(FP(S-out))), where LT is the Serpent linear transform on words W0=[31:0]..W3=[127:96].
    - For r=31: X <= S-out, with no LT.
    - r <= r+1. After r=31, go to FINAL.
  - FINAL, with o_address=32:
    - o_data <= FP(X ^ i_key); o_data_valid <= 1; go to IDLE.
- The block contains the eight forward S-boxes (S0..S7, standard tables) and the LT.
- IP and FP are instances of the existing `initial_permutation` and `final_permutation` modules: one each at the input and output, plus one pair inside LT'.
- i_en while busy: ignored.
- A new start is accepted in the cycle o_data_valid is high; back-to-back operation is allowed.
- Reset values: state IDLE, r=0, X=0, o_data=0, o_data_valid=0, o_busy=0, o_address=0.
- Reset mid-operation: immediate return to IDLE. No valid pulse is produced and o_data is cleared to 0.
- r is 6 bits and never exceeds 32; there is no wrap-around.

## Timing
- Start edge E0 is the edge at which IDLE samples i_en & i_subkey_valid.
- Edges E1..E32 execute rounds 0..31.
- Edge E33 executes FINAL.
- o_data_valid is high during the cycle after E33, i.e. 34 cycles after the start edge, for exactly one cycle. o_data is valid from that cycle onward.
- Throughput is one block per 34 cycles.
- o_address changes only on clock edges. i_key must settle within the same cycle; the store read is combinational.
- o_busy is high from the cycle after E0 through the cycle after E32.

## Configuration
- Macro: `SERPENT_ENC_ABORT_EN`.
- Defined:
  - If i_subkey_valid is low at any edge in ROUND or FINAL, the block returns to IDLE.
  - No o_data_valid pulse is produced and o_data keeps its previous value.
  - This guards against a key reload during an operation.
- Undefined:
  - i_subkey_valid is checked only at the start edge.
  - The operation always completes in 34 cycles regardless of later i_subkey_valid.

## Test plan
- Start with i_data=0 and all 33 subkeys taken from a golden key schedule for the all-zero 128-bit key. The result must equal the software reference ciphertext. o_data_valid must rise exactly 34 cycles after the start edge and last one cycle.
- Loopback: encrypt 128'h00112233445566778899AABBCCDDEEFF, then feed the ciphertext to the decryption core with the same store. Decryption must return the original plaintext. Repeat with 100 random plaintext/key pairs.
- Back-to-back: hold i_en high with i_subkey_valid=1 for two blocks. The second start must be accepted in the valid cycle, and the two valid pulses must be 34 cycles apart with correct data for both.
- Address sequence: o_address must read 0 in IDLE, then 0..31 during ROUND, then 32 in FINAL, checked against the cycle count. i_en pulses mid-operation must have no effect.
- Abort (macro defined): drop i_subkey_valid at round 10. The block must return to IDLE and clear o_busy, with no valid pulse and o_data unchanged. With the macro undefined, the same stimulus must produce the correct ciphertext at cycle 34.
- Reset: assert i_rstn=0 at round 20. All outputs must read 0 immediately. A fresh start after release must produce the correct result.
